spi_listener: RTL and testbench
===============================

Name: spi_listener

Overview:
- Byte-to-word assembler behind an SPI slave receiver.
- Collects three consecutive received bytes into one 24-bit word, MSB first.
- Publishes the word and pulses an interrupt for one cycle.
- An inter-byte timeout discards partial frames so the assembler resynchronises after a broken or short transfer.

Parameters:
- TIMEOUT, 100: idle clock cycles allowed between bytes of one frame before the partial frame is discarded. Range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- spi_slave_data_valid  input  1  one-cycle strobe; spi_slave_byte is valid this cycle.
- spi_slave_byte  input  8  received byte; sampled only when the strobe is high.
- spi_data  output  24  last completed frame; {byte0, byte1, byte2}, byte0 in [23:16].
- spi_listener_interrupt  output  1  one-cycle pulse when spi_data is updated.
- timeout_cnt  output  16  idle-cycle counter of the frame in progress (status/debug).

Behaviour:
- Reset (async, rst=1): spi_data=0, spi_listener_interrupt=0, timeout_cnt=0, byte index=0, partial-byte registers=0. Reset mid-frame discards the partial frame.
- Byte index states: IDLE(0), GOT1(1), GOT2(2).
- Strobe in IDLE:
  - store byte into [23:16] of the shadow register;
  - go to GOT1;
  - timeout_cnt <= 0.
- Strobe in GOT1:
  - store byte into [15:8];
  - go to GOT2;
  - timeout_cnt <= 0.
- Strobe in GOT2:
  - spi_data <= {b0, b1, new byte} at that same clock edge;
  - spi_listener_interrupt <= 1 for exactly one cycle;
  - return to IDLE;
  - timeout_cnt <= 0.
- Latency: spi_data and the interrupt are visible in the cycle after the edge that samples the third strobe.
- spi_data holds its value until the next completed frame. Partial frames never change spi_data.
- timeout_cnt:
  - held at 0 in IDLE;
  - in GOT1/GOT2, increments by 1 on each cycle without a strobe.
- Timeout: when timeout_cnt == TIMEOUT-1 and no strobe arrives that cycle:
  - next state is IDLE;
  - timeout_cnt <= 0;
  - no interrupt.
  - A frame is therefore discarded after TIMEOUT strobe-free cycles.
- Simultaneous strobe and timeout threshold: the strobe wins. The byte is appended to the current frame and the counter clears.
- Strobe held high for multiple cycles: each high cycle is a separate byte. The upstream block guarantees single-cycle strobes.
- Interrupt is never asserted by reset, timeout or a partial frame.
- No counter wrap is possible: the counter never exceeds TIMEOUT-1.

Optional Feature:
- Macro: SPI_LISTENER_TIMEOUT_EN.
- Defined: the timeout logic operates as specified above.
- Undefined:
  - timeout_cnt is tied to 0 and the TIMEOUT parameter is ignored;
  - partial frames persist indefinitely;
  - framing advances strictly every three strobes after reset.

Test Plan:
- Clock 10 ns, TIMEOUT=100, strobes 10 cycles apart, macro defined. Bytes A2,BB,CC -> one interrupt pulse; spi_data=0xA2BBCC.
- Continue with 00,20, then 200 idle cycles -> no interrupt; spi_data stays 0xA2BBCC; timeout_cnt climbs to 99 then returns to 0 and the state returns to IDLE.
- Then CC,30,20 -> interrupt; spi_data=0xCC3020. This proves resync after a timeout.
- Then BB,CC and end of stimulus -> no interrupt; spi_data stays 0xCC3020; partial frame flushed after 100 cycles.
- Strobe exactly on the cycle timeout_cnt==99 after byte 1 -> byte accepted as byte 2; the next strobe completes the frame.
- Async reset asserted between byte 1 and byte 2 -> all outputs 0 immediately. Three fresh bytes 11,22,33 -> spi_data=0x112233.
- Macro undefined: 00,20, 200 idle cycles, then CC -> spi_data=0x0020CC; timeout_cnt always 0.

Source files
------------

// File: rtl/spi_listener.sv
// spi_listener: packs three SPI bytes (MSB first) into a 24-bit word and pulses an interrupt.
// Define SPI_LISTENER_TIMEOUT_EN to enable the inter-byte timeout that discards partial frames.
module spi_listener #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_slave_data_valid,
  input  logic [7:0]  spi_slave_byte,
  output logic [23:0] spi_data,
  output logic        spi_listener_interrupt,
  output logic [15:0] timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [23:0] data_q, data_d;
  logic        irq_q, irq_d;
  logic [15:0] cnt_q, cnt_d;
  logic        expired_s;

`ifdef SPI_LISTENER_TIMEOUT_EN
  assign expired_s = (cnt_q == TO_LAST);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TO_LAST;
  assign expired_s        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      b0_q    <= 8'd0;
      b1_q    <= 8'd0;
      data_q  <= 24'd0;
      irq_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    data_d  = data_q;
    irq_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (spi_slave_data_valid) begin
          b0_d    = spi_slave_byte;
          state_d = GOT1;
        end else begin
          state_d = IDLE;
        end
      end

      GOT1, GOT2: begin
        if (spi_slave_data_valid) begin
          // A strobe always wins over the timeout threshold.
          cnt_d = 16'd0;
          if (state_q == GOT1) begin
            b1_d    = spi_slave_byte;
            state_d = GOT2;
          end else begin
            data_d  = {b0_q, b1_q, spi_slave_byte};
            irq_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (expired_s) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else begin
`ifdef SPI_LISTENER_TIMEOUT_EN
          cnt_d = cnt_q + 16'd1;
`else
          cnt_d = 16'd0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign spi_data               = data_q;
  assign spi_listener_interrupt = irq_q;
  assign timeout_cnt            = cnt_q;

endmodule

// File: tb/tb_spi_listener.sv
// Directed self-checking bench for spi_listener; expectations follow SPI_LISTENER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_spi_listener;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  data_byte;
  logic [23:0] spi_data;
  logic        irq;
  logic [15:0] tcnt;

  int checks = 0;
  int errors = 0;
  int irq_pulses = 0;

  spi_listener #(.TIMEOUT(100)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .spi_slave_data_valid   (valid),
    .spi_slave_byte         (data_byte),
    .spi_data               (spi_data),
    .spi_listener_interrupt (irq),
    .timeout_cnt            (tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq === 1'b1) irq_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle starting at a negedge; returns at the next negedge.
  task automatic strobe(input logic [7:0] b);
    valid     = 1'b1;
    data_byte = b;
    @(negedge clk);
    valid     = 1'b0;
    data_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    valid     = 1'b0;
    data_byte = 8'h00;
    idle(3);
    check("reset_data", {8'd0, spi_data}, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    check("reset_cnt", {16'd0, tcnt}, 32'h0);
    rst = 1'b0;
    idle(2);

`ifdef SPI_LISTENER_TIMEOUT_EN
    // Frame A2 BB CC
    strobe(8'hA2);
    check("cnt_after_b0", {16'd0, tcnt}, 32'd0);
    idle(9);
    check("cnt_idle9", {16'd0, tcnt}, 32'd9);
    strobe(8'hBB); idle(9);
    strobe(8'hCC);
    check("irq_frame1", {31'd0, irq}, 32'h1);
    check("data_frame1", {8'd0, spi_data}, 32'h00A2BBCC);
    idle(1);
    check("irq_one_cycle", {31'd0, irq}, 32'h0);
    idle(8);

    // Partial 00 20 then timeout
    strobe(8'h00); idle(9);
    strobe(8'h20);
    idle(99);
    check("cnt_at_99", {16'd0, tcnt}, 32'd99);
    idle(1);
    check("cnt_wrapped_0", {16'd0, tcnt}, 32'd0);
    idle(100);
    check("cnt_idle_0", {16'd0, tcnt}, 32'd0);
    check("data_hold1", {8'd0, spi_data}, 32'h00A2BBCC);
    check("pulses_after_to", irq_pulses, 32'd1);

    // Resync: CC 30 20
    strobe(8'hCC); idle(9);
    strobe(8'h30); idle(9);
    strobe(8'h20);
    check("irq_frame2", {31'd0, irq}, 32'h1);
    check("data_frame2", {8'd0, spi_data}, 32'h00CC3020);
    idle(9);

    // Partial BB CC flushed
    strobe(8'hBB); idle(9);
    strobe(8'hCC);
    idle(50);
    check("cnt_50", {16'd0, tcnt}, 32'd50);
    idle(49);
    check("cnt_99b", {16'd0, tcnt}, 32'd99);
    idle(1);
    check("cnt_flushed", {16'd0, tcnt}, 32'd0);
    check("data_hold2", {8'd0, spi_data}, 32'h00CC3020);
    check("pulses_after_flush", irq_pulses, 32'd2);
    idle(5);

    // Strobe exactly at threshold is accepted
    strobe(8'h5A);
    idle(99);
    check("cnt_thresh", {16'd0, tcnt}, 32'd99);
    strobe(8'h6B);
    check("cnt_clear_on_strobe", {16'd0, tcnt}, 32'd0);
    check("irq_thresh_b1", {31'd0, irq}, 32'h0);
    idle(3);
    strobe(8'h7C);
    check("irq_frame3", {31'd0, irq}, 32'h1);
    check("data_frame3", {8'd0, spi_data}, 32'h005A6B7C);
    idle(9);
`else
    // No timeout: 00 20, long idle, then CC completes the frame
    strobe(8'h00); idle(9);
    strobe(8'h20);
    idle(100);
    check("cnt_tied0_a", {16'd0, tcnt}, 32'd0);
    idle(100);
    check("cnt_tied0_b", {16'd0, tcnt}, 32'd0);
    check("pulses_partial", irq_pulses, 32'd0);
    strobe(8'hCC);
    check("irq_frame1", {31'd0, irq}, 32'h1);
    check("data_frame1", {8'd0, spi_data}, 32'h000020CC);
    idle(1);
    check("irq_one_cycle", {31'd0, irq}, 32'h0);
    idle(8);

    strobe(8'hA2); idle(9);
    strobe(8'hBB); idle(9);
    check("data_hold_partial", {8'd0, spi_data}, 32'h000020CC);
    strobe(8'hCC);
    check("data_frame2", {8'd0, spi_data}, 32'h00A2BBCC);
    idle(9);

    strobe(8'h5A); idle(300);
    check("cnt_tied0_c", {16'd0, tcnt}, 32'd0);
    strobe(8'h6B); idle(2);
    strobe(8'h7C);
    check("irq_frame3", {31'd0, irq}, 32'h1);
    check("data_frame3", {8'd0, spi_data}, 32'h005A6B7C);
    idle(9);
`endif

    // Async reset mid-frame clears everything immediately
    strobe(8'h44);
    idle(5);
    #2 rst = 1'b1;
    #1;
    check("arst_data", {8'd0, spi_data}, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'h0);
    check("arst_cnt", {16'd0, tcnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    strobe(8'h11); idle(9);
    strobe(8'h22); idle(9);
    strobe(8'h33);
    check("irq_after_rst", {31'd0, irq}, 32'h1);
    check("data_after_rst", {8'd0, spi_data}, 32'h00112233);
    idle(3);
    check("pulses_total", irq_pulses, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
